// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, tracks the single in-flight
// read to instruction_mem and buffers responses in a 2-entry skid FIFO for decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  state_t      state, state_next;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  entry_t      fifo [DEPTH];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop, push, issue;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: give every combinationally assigned signal a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Credit rule: an issue needs a FIFO slot for its response, counting the
  // word already in flight; a same-cycle pop frees one slot.
  always_comb begin
    occupancy = {1'b0, count} + {2'b00, inflight};
    out_valid = (count != 2'd0) & ~redirect_valid;
    pop       = out_valid & out_ready;
    push      = inflight & ~redirect_valid;
    issue     = (state == RUN) & fetch_en & ~redirect_valid &
                ((occupancy < DEPTH_W) | ((occupancy == DEPTH_W) & pop));
    busy      = (state == RUN) | inflight | (count != 2'd0);
  end

  // NOTE: the FIFO storage is reset too, so out_instr/out_pc read 0 out of reset
  // instead of whatever the flops powered up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo[wr_ptr] <= '{instr: imem_instr, pc: inflight_pc};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= 32'h0;
    else if ((state == RUN) && out_ready && !out_valid && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

  assign imem_addr = fetch_pc;
  assign out_instr = fifo[rd_ptr].instr;
  assign out_pc    = fifo[rd_ptr].pc;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the synchronous instruction_mem. It owns the fetch PC and drives the memory address every cycle. It also tracks the one-cycle-latency read in flight and buffers returned words in a 2-entry skid FIFO, which is presented to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard the in-flight read.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (low 2 bits must be 0)
DEPTH, 2, output FIFO entries (fixed at 2; occupancy counter 2 bits)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = issue fetches; 0 = stop issuing, drain
imem_addr  output  32  address to instruction_mem (instr_addr)
imem_instr  input  32  read data from instruction_mem (instr), valid the cycle after address is sampled
redirect_valid  input  1  one-cycle pulse: change fetch stream
redirect_pc  input  32  new target; bits [1:0] ignored (forced 0)
out_valid  output  1  FIFO head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  instruction at FIFO head
out_pc  output  32  PC of out_instr
busy  output  1  1 when state=RUN or in-flight read or FIFO non-empty
stall_cycles  output  32  perf counter

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, imem_addr=RESET_PC, FIFO empty, inflight=0, out_valid=0, out_instr=0, out_pc=0, busy=0, stall_cycles=0, state=IDLE.
- imem_addr = fetch_pc register (no combinational path from inputs).
- Memory timing: edge E samples imem_addr=A. imem_instr=mem[A] during the cycle after E.
- FSM: IDLE -> RUN when fetch_en=1. RUN -> IDLE when fetch_en=0. No issue in IDLE. In-flight read still completes and FIFO still drains.
- pop = out_valid & out_ready & ~redirect_valid.
- issue = (state==RUN) & fetch_en & ~redirect_valid & ((count+inflight) < DEPTH | ((count+inflight)==DEPTH & pop)).
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000). Else inflight<=0.
- Response: when inflight=1 and no redirect, push {imem_instr, inflight_pc} to FIFO tail. The credit rule guarantees no overflow.
- Push and pop in the same cycle: both happen; count unchanged.
- Push into an empty FIFO is visible on out_valid the next cycle (no bypass).
- out_valid = (count!=0) & ~redirect_valid. out_instr/out_pc are the head entry. Both hold stable while out_valid=1 & out_ready=0.
- Redirect (has priority over everything):
  - fetch_pc<=redirect_pc & ~3.
  - FIFO cleared; inflight<=0, and the response arriving next cycle is discarded.
  - No pop and no issue that cycle.
  - First issue to the target occurs the next cycle if in RUN.
- Latency: first issue at cycle of fetch_en=1 (RUN). Corresponding out_valid rises 2 cycles after that issue edge (issue cycle T: addr; T+1: data pushed; T+2: out_valid). Same for redirect: target instr valid at redirect cycle +3.
- Throughput: with out_ready held 1, one instruction per cycle sustained.
- stall_cycles increments by 1 (saturating at FFFF_FFFF) each cycle with state==RUN & out_ready & ~out_valid.
- busy = (state==RUN) | inflight | (count!=0).

Test Plan:
- Reset with RESET_PC=0, fetch_en=1, out_ready=1, memory holding word 0x0000_0013+4k at addr 4k -> out_valid first high 2 cycles after first issue. Then out_pc 0,4,8,... with matching out_instr, one per cycle. stall_cycles=2 after startup.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> FIFO fills (count=2), issue stops, imem_addr frozen, head unchanged. Release -> stream resumes with no skipped or duplicated PC.
- Redirect: assert redirect_valid with redirect_pc=0x0000_0103 while FIFO full and read in flight -> out_valid=0 that cycle. Next delivered out_pc=0x0000_0100, 3 cycles later. No stale words appear.
- Simultaneous redirect and out_valid&out_ready -> no handshake counted; old head is never delivered.
- fetch_en drop: deassert with 1 in flight -> in-flight word still delivered, then out_valid=0, busy falls to 0 once FIFO drains, imem_addr holds. PC wrap: RESET_PC=0xFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream (rst pulse between clock edges) -> outputs clear immediately and imem_addr=RESET_PC. After release, fetch restarts from RESET_PC.
